lru_way_select: RTL and testbench



---
 rtl/lru_way_select_if.sv | 29 ++
 rtl/lru_way_select.sv | 99 +++++++++
 tb/tb_lru_way_select.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lru_way_select_if.sv
// lru_way_select_if: bus between the dcache controller and the LRU replacement unit
//   slave  (replacement unit): takes touch/victim_req/fill_done/flush_req; drives victim_valid/victim_way/busy/flush_done
//   master (controller):       the opposite directions
interface lru_way_select_if #(
  parameter int WAYS = 4,
  parameter int SETS = 8,
  parameter int WAY_W = $clog2(WAYS),
  parameter int IDX_W = $clog2(SETS)
);
  logic             touch;
  logic [IDX_W-1:0] touch_idx;
  logic [WAY_W-1:0] touch_way;
  logic             victim_req;
  logic [IDX_W-1:0] victim_idx;
  logic             victim_valid;
  logic [WAY_W-1:0] victim_way;
  logic             fill_done;
  logic             flush_req;
  logic             busy;
  logic             flush_done;
  modport slave (
    input  touch, touch_idx, touch_way, victim_req, victim_idx, fill_done, flush_req,
    output victim_valid, victim_way, busy, flush_done
  );
  modport master (
    output touch, touch_idx, touch_way, victim_req, victim_idx, fill_done, flush_req,
    input  victim_valid, victim_way, busy, flush_done
  );
endinterface

// File: rtl/lru_way_select.sv
// lru_way_select: per-set true-LRU replacement with registered victim hold and invalidate sweep
//   CLK, RST (async, active-high) plain ports; bus (slave modport) carries hits, victim
//   request/response, fill commit, flush request, busy and the flush_done pulse.
module lru_way_select #(
  parameter int WAYS = 4,
  parameter int SETS = 8,
  parameter int WAY_W = $clog2(WAYS),
  parameter int IDX_W = $clog2(SETS)
) (
  input logic CLK,
  input logic RST,
  lru_way_select_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;
  logic [1:0]       state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] hold_idx;
  logic [WAY_W-1:0] vway;
  logic             fdone;
  logic [WAYS-1:0]  valid [SETS];
  ages_t            age [SETS];
  logic [WAY_W-1:0] sel_way;
  ages_t            touch_row;
  ages_t            fill_row;
  // Ages below the promoted way's age shift up by one, so they never exceed WAYS-1.
  function automatic ages_t promote(input ages_t a, input logic [WAY_W-1:0] w);
    promote = a;
    for (int i = 0; i < WAYS; i++)
      if (a[i] < a[w]) promote[i] = a[i] + 1'b1;
    promote[w] = '0;
  endfunction
  // Lowest-index invalid way wins; otherwise the LRU way. The descending pass overrides the LRU pick.
  always_comb begin
    sel_way = '0;
    for (int i = 0; i < WAYS; i++)
      if (age[bus.victim_idx][i] == WAY_W'(WAYS - 1)) sel_way = i[WAY_W-1:0];
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid[bus.victim_idx][i]) sel_way = i[WAY_W-1:0];
  end
  assign touch_row = promote(age[bus.touch_idx], bus.touch_way);
  assign fill_row = promote(age[hold_idx], vway);
  assign bus.victim_valid = state == HOLD;
  assign bus.victim_way = vway;
  assign bus.busy = state != IDLE;
  assign bus.flush_done = fdone;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      hold_idx <= '0;
      vway <= '0;
      fdone <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        for (int w = 0; w < WAYS; w++) age[s][w] <= w[WAY_W-1:0];
      end
    end else begin
      fdone <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            state <= FLUSH;
            cnt <= '0;
          end else begin
            if (bus.victim_req) begin
              vway <= sel_way;
              hold_idx <= bus.victim_idx;
              state <= HOLD;
            end
            if (bus.touch) age[bus.touch_idx] <= touch_row;
          end
        end
        HOLD: begin
          if (bus.flush_req) begin
            state <= FLUSH;
            cnt <= '0;
          end else if (bus.fill_done) begin
            valid[hold_idx][vway] <= 1'b1;
            age[hold_idx] <= fill_row;
            state <= IDLE;
          end
        end
        FLUSH: begin
          valid[cnt] <= '0;
          for (int w = 0; w < WAYS; w++) age[cnt][w] <= w[WAY_W-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(SETS - 1)) begin
            fdone <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lru_way_select.sv
// tb_lru_way_select: directed self-checking bench for lru_way_select (WAYS=4, SETS=8)
module tb_lru_way_select;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  lru_way_select_if #(.WAYS(4), .SETS(8)) bus ();
  lru_way_select #(.WAYS(4), .SETS(8)) dut (.CLK(clk), .RST(rst), .bus(bus));
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input int idx, input int exp_way, input string tag);
    bus.victim_req = 1'b1;
    bus.victim_idx = 3'(idx);
    tick();
    bus.victim_req = 1'b0;
    check({tag, "_vv"}, int'(bus.victim_valid), 1);
    check({tag, "_way"}, int'(bus.victim_way), exp_way);
  endtask
  task automatic fill(input string tag);
    bus.fill_done = 1'b1;
    tick();
    bus.fill_done = 1'b0;
    check({tag, "_vv0"}, int'(bus.victim_valid), 0);
  endtask
  task automatic touch(input int idx, input int way);
    bus.touch = 1'b1;
    bus.touch_idx = 3'(idx);
    bus.touch_way = 2'(way);
    tick();
    bus.touch = 1'b0;
  endtask
  initial begin
    bus.touch = 1'b0;
    bus.touch_idx = '0;
    bus.touch_way = '0;
    bus.victim_req = 1'b0;
    bus.victim_idx = '0;
    bus.fill_done = 1'b0;
    bus.flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_vv", int'(bus.victim_valid), 0);
    check("rst_way", int'(bus.victim_way), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_fd", int'(bus.flush_done), 0);
    // Empty set 3 fills ways 0..3 in order; ages end {3,2,1,0}
    for (int w = 0; w < 4; w++) begin
      req(3, w, "s3_fill");
      check("s3_busy", int'(bus.busy), 1);
      fill("s3_fill");
    end
    check("s3_idle_busy", int'(bus.busy), 0);
    touch(3, 1);
    req(3, 0, "s3_lru0");
    fill("s3_lru0");
    touch(3, 0);
    req(3, 2, "s3_lru2");
    fill("s3_lru2");
    // Set 5 full with ages {1,3,0,2}
    for (int w = 0; w < 4; w++) begin
      req(5, w, "s5_fill");
      fill("s5_fill");
    end
    touch(5, 3);
    touch(5, 0);
    touch(5, 2);
    bus.touch = 1'b1;
    bus.touch_idx = 3'd5;
    bus.touch_way = 2'd1;
    req(5, 1, "s5_prepromote");
    bus.touch = 1'b0;
    fill("s5_prepromote");
    req(5, 3, "s5_after");
    fill("s5_after");
    req(5, 0, "s5_after2");
    fill("s5_after2");
    // HOLD on set 2 ignores touch and a second request aimed at full set 3
    req(2, 0, "s2_hold");
    bus.touch = 1'b1;
    bus.touch_idx = 3'd2;
    bus.touch_way = 2'd3;
    bus.victim_req = 1'b1;
    bus.victim_idx = 3'd3;
    tick();
    bus.touch = 1'b0;
    bus.victim_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s2_hold_vv", int'(bus.victim_valid), 1);
      check("s2_hold_way", int'(bus.victim_way), 0);
    end
    fill("s2_hold");
    req(2, 1, "s2_next");
    fill("s2_next");
    // Flush with fill_done in HOLD aborts the fill
    req(6, 0, "s6_hold");
    bus.flush_req = 1'b1;
    bus.fill_done = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    bus.fill_done = 1'b0;
    check("fl_vv", int'(bus.victim_valid), 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check("fl_busy", int'(bus.busy), 1);
      check("fl_fd_low", int'(bus.flush_done), 0);
    end
    tick();
    check("fl_done", int'(bus.flush_done), 1);
    check("fl_idle", int'(bus.busy), 0);
    tick();
    check("fl_pulse", int'(bus.flush_done), 0);
    req(3, 0, "fl_s3");
    fill("fl_s3");
    req(6, 0, "fl_s6");
    fill("fl_s6");
    req(5, 0, "fl_s5");
    fill("fl_s5");
    // Reset mid-sweep at counter=4; set 7 must come back empty
    req(7, 0, "s7_pre");
    fill("s7_pre");
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    check("rf_busy", int'(bus.busy), 1);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("rf_busy0", int'(bus.busy), 0);
    check("rf_fd0", int'(bus.flush_done), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rf_no_fd", int'(bus.flush_done), 0);
    end
    req(7, 0, "rf_s7");
    fill("rf_s7");
    req(2, 0, "rf_s2");
    fill("rf_s2");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
